ks_pipe_adder: RTL
==================

Name: ks_pipe_adder

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor. It is the next-generation successor to the team's fixed 4-bit prefix adder.
- Generalised to N bits, with registered prefix levels, carry-in, subtract mode and a valid/ready streaming handshake.
- Sits in the datapath as a full-throughput arithmetic stage: one operation accepted per cycle when not stalled.

Parameters:
- N, 16, operand width in bits; any value >= 2.
- LEVELS, derived (not overridable) = clog2(N), number of prefix levels.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_a  input  N  operand A.
- in_b  input  N  operand B.
- in_cin  input  1  carry-in; ignored when in_sub=1.
- in_sub  input  1  1 = A - B, computed as A + ~B + 1.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the beat.
- out_sum  output  N  sum/difference, modulo 2^N.
- out_cout  output  1  carry out of MSB. In subtract mode 1 = no borrow.
- out_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Pipeline structure, in stage order:
  - stage 0 registers the inputs and computes bitwise g = a&b' and p = a^b', where b' = in_sub ? ~in_b : in_b;
  - carry-in cin' = in_sub ? 1 : in_cin, injected as the generate term of a virtual bit -1;
  - stages 1..LEVELS each hold one Kogge-Stone level with span 2^(k-1). Grey cells compute (G,P) = (Gh | Ph&Gl, Ph&Pl); white cells at already-resolved positions pass through;
  - the final stage computes sum[i] = p[i] ^ G[i-1:-1], cout = G[N-1:-1], ovf = carry into MSB ^ cout.
- Latency: exactly LEVELS+2 cycles from an accepted input beat to out_valid (N=16 -> 6). Throughput is 1 beat/cycle.
- Each stage carries a valid bit alongside its data.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
  - A beat is accepted when in_valid & in_ready.
  - While stall=1, every pipeline register, including the valid bits, holds its value. out_* stay stable and unchanged until out_ready.
  - When stall=0, all stages advance. A bubble (in_valid=0) propagates as valid=0.
  - A beat is consumed on out_valid & out_ready.
  - Simultaneous consume and accept in the same cycle is legal and sustains full rate.
- Reset:
  - All valid bits clear immediately on rst. out_valid=0, out_sum=0, out_cout=0, out_ovf=0, in_ready=1.
  - In-flight beats are discarded. No beat may emerge after reset deassertion unless it was accepted after deassertion.
- Boundaries:
  - All-ones + 1 wraps to 0 with cout=1.
  - N not a power of two: levels use span 2^(k-1) clipped at bit 0, and LEVELS=clog2(N) (e.g. N=12 -> 4 levels, latency 6).
- out_ovf is defined in both modes as carry into bit N-1 XOR carry out of bit N-1.

Optional Feature:
- Macro KS_FLAGS_EN.
- When defined: adds output ports out_zero (1 when out_sum==0) and out_neg (= out_sum[N-1]). Both are registered with the final stage, follow the same stall/hold rules, and reset to 0.
- When undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan (N=16):
- add 0xFFFF + 0x0001, cin=0, sub=0 -> after 6 cycles: sum=0x0000, cout=1, ovf=0 (with KS_FLAGS_EN: zero=1, neg=0).
- add 0x7FFF + 0x0001 -> sum=0x8000, cout=0, ovf=1; separately 0x1234 + 0x0001 with cin=1 -> sum=0x1236, cout=0, ovf=0.
- sub 0x0000 - 0x0001 (cin=1 ignored) -> sum=0xFFFF, cout=0, ovf=0; sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure:
  - stream 10 back-to-back beats and hold out_ready=0 for 4 cycles once out_valid rises;
  - required: in_ready=0 throughout the stall, out_* stable, no beat lost or duplicated;
  - after release, beats emerge in order at 1/cycle.
- Reset mid-flight: assert rst with 5 beats in the pipeline -> out_valid=0 within the same cycle, all outputs 0, and no stale beat after release.
- Randomised N=16 and N=12 builds, 10k beats with random in_valid/out_ready -> every result matches the golden model {cout,sum} = A + (sub ? ~B+1 : B+cin) and ovf, in order.

Source files
------------

// File: rtl/ks_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream and one prefix level per stage.
// Optional out_zero/out_neg flag outputs are enabled by defining KS_FLAGS_EN.
module ks_pipe_adder #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_cin,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout,
    output logic         out_ovf
`ifdef KS_FLAGS_EN
    ,
    output logic         out_zero,
    output logic         out_neg
`endif
);
    localparam int LEVELS = $clog2(N);

    // Tree position j holds bit j-1; position 0 is the virtual carry-in bit.
    logic [N-1:0] tg_q [0:LEVELS];
    logic [N-1:0] tg_d [0:LEVELS];
    logic [N-1:0] tp_q [0:LEVELS-1];
    logic [N-1:0] tp_d [0:LEVELS-1];
    logic [N-1:0] p_q  [0:LEVELS];
    logic [N-1:0] p_d  [0:LEVELS];
    logic         gm_q [0:LEVELS];
    logic         gm_d [0:LEVELS];
    logic         v_q  [0:LEVELS];
    logic         v_d  [0:LEVELS];

    logic [N-1:0] sum_q, sum_d;
    logic         cout_q, cout_d;
    logic         ovf_q, ovf_d;
    logic         ov_q, ov_d;
`ifdef KS_FLAGS_EN
    logic         zero_q, zero_d;
    logic         neg_q, neg_d;
`endif

    logic [N-1:0] b_s;
    logic [N-1:0] g_s;
    logic [N-1:0] c_s;
    logic         cin_s;
    logic         stall_s;

    assign stall_s  = ov_q & ~out_ready;
    assign in_ready = ~stall_s;

    // Operand conditioning and the prefix levels
    always_comb begin
        b_s      = in_sub ? ~in_b : in_b;
        cin_s    = in_sub | in_cin;
        g_s      = in_a & b_s;
        p_d[0]   = in_a ^ b_s;
        tg_d[0]  = {g_s[N-2:0], cin_s};
        tp_d[0]  = {p_d[0][N-2:0], 1'b0};
        gm_d[0]  = g_s[N-1];
        v_d[0]   = in_valid;
        for (int k = 1; k <= LEVELS; k++) begin
            p_d[k]  = p_q[k-1];
            gm_d[k] = gm_q[k-1];
            v_d[k]  = v_q[k-1];
            // Positions below the span see shifted-in zeros and pass straight through.
            tg_d[k] = tg_q[k-1] | (tp_q[k-1] & (tg_q[k-1] << (1 << (k-1))));
        end
        for (int k = 1; k < LEVELS; k++) begin
            tp_d[k] = tp_q[k-1] & ((tp_q[k-1] << (1 << (k-1))) | ~({N{1'b1}} << (1 << (k-1))));
        end
    end

    // Final sum, carry-out and overflow from the resolved carries
    always_comb begin
        c_s    = tg_q[LEVELS];
        sum_d  = p_q[LEVELS] ^ c_s;
        cout_d = gm_q[LEVELS] | (p_q[LEVELS][N-1] & c_s[N-1]);
        ovf_d  = c_s[N-1] ^ cout_d;
        ov_d   = v_q[LEVELS];
`ifdef KS_FLAGS_EN
        zero_d = (sum_d == {N{1'b0}});
        neg_d  = sum_d[N-1];
`endif
    end

    // Pipeline registers: all stages advance together unless the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= LEVELS; k++) begin
                tg_q[k] <= {N{1'b0}};
                p_q[k]  <= {N{1'b0}};
                gm_q[k] <= 1'b0;
                v_q[k]  <= 1'b0;
            end
            for (int k = 0; k < LEVELS; k++) begin
                tp_q[k] <= {N{1'b0}};
            end
            sum_q  <= {N{1'b0}};
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            ov_q   <= 1'b0;
`ifdef KS_FLAGS_EN
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
`endif
        end else if (!stall_s) begin
            for (int k = 0; k <= LEVELS; k++) begin
                tg_q[k] <= tg_d[k];
                p_q[k]  <= p_d[k];
                gm_q[k] <= gm_d[k];
                v_q[k]  <= v_d[k];
            end
            for (int k = 0; k < LEVELS; k++) begin
                tp_q[k] <= tp_d[k];
            end
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            ov_q   <= ov_d;
`ifdef KS_FLAGS_EN
            zero_q <= zero_d;
            neg_q  <= neg_d;
`endif
        end
    end

    assign out_valid = ov_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
`ifdef KS_FLAGS_EN
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;
`endif

endmodule
